controle_num_pessoas: RTL



---
 rtl/controle_num_pessoas.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/controle_num_pessoas.sv
// Occupancy controller for the DecNumPessoas 7-segment decoder.
//
// Each raw sensor goes through a 2-FF synchronizer, an optional debouncer and a
// rising-edge detector. The resulting one-cycle events drive a 3-bit counter
// that saturates in 0..MAX_PESSOAS. A retriggerable alarm flags entries
// rejected at full capacity.
//
// Build option:
//   CTRL_PESSOAS_DEBOUNCE_EN  defined   -> debouncers present (DEB_CYCLES used)
//                             undefined -> synchronized level feeds the edge
//                                          detector directly
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   sens_in   raw entry sensor (asynchronous, active high)
//   sens_out  raw exit sensor (asynchronous, active high)
//   clr       synchronous clear of count and alarm
//   A, B, C   count bits 2..0 to the decoder
//   cheio     count == MAX_PESSOAS
//   vazio     count == 0
//   alarme    rejected-entry alarm, high ALARM_CYCLES cycles (retriggerable)
//
// Reset behaviour: a sensor must be seen low after reset before its rising
// edges are counted. A sensor held high across reset release is therefore
// ignored until it falls and rises again, even though the filtered level
// restarts at 0 and would otherwise show a rise once debounced.

module controle_num_pessoas #(
  parameter int unsigned MAX_PESSOAS  = 7,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned ALARM_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sens_in,
  input  logic sens_out,
  input  logic clr,
  output logic A,
  output logic B,
  output logic C,
  output logic cheio,
  output logic vazio,
  output logic alarme
);

  localparam logic [2:0]      MaxCnt  = 3'(MAX_PESSOAS);
  localparam int unsigned     AlmW    = $clog2(ALARM_CYCLES + 1);
  localparam logic [AlmW-1:0] AlmLoad = AlmW'(ALARM_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StAlarm} alm_st_e;

  // Index 0 = entry sensor, index 1 = exit sensor.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] lvl;
  logic [1:0] prev_q;
  logic [1:0] ready_q;
  logic [1:0] armed_q, armed_d;
  logic [1:0] ev;
  logic       ev_in, ev_out;

  assign raw = {sens_out, sens_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef CTRL_PESSOAS_DEBOUNCE_EN
  localparam int unsigned    DebW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

  logic [1:0]           filt_q, filt_d;
  logic [1:0][DebW-1:0] deb_cnt_q, deb_cnt_d;

  // Counter runs only while the synchronized level disagrees with the filtered
  // one; any agreement restarts it, so short pulses never get through.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          filt_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;

  assign lvl = sync2_q;
`endif

  // ready_q[1] marks that sync2_q holds a real post-reset sample; a sensor is
  // armed once such a sample shows it low.
  assign armed_d = armed_q | ({2{ready_q[1]}} & ~sync2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      ready_q <= '0;
      armed_q <= '0;
    end else begin
      prev_q  <= lvl;
      ready_q <= {ready_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign ev     = lvl & ~prev_q & armed_q;
  assign ev_in  = ev[0];
  assign ev_out = ev[1];

  // Count update and alarm trigger.
  logic [2:0] count_q, count_d;
  logic       trig;

  always_comb begin
    count_d = count_q;
    trig    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (ev_in && ev_out) begin
      count_d = count_q;
    end else if (ev_in) begin
      if (count_q < MaxCnt) begin
        count_d = count_q + 3'd1;
      end else begin
        trig = 1'b1;
      end
    end else if (ev_out) begin
      if (count_q != 3'd0) begin
        count_d = count_q - 3'd1;
      end
    end
  end

  // Alarm FSM.
  alm_st_e         st_q, st_d;
  logic [AlmW-1:0] alm_cnt_q, alm_cnt_d;

  always_comb begin
    st_d      = st_q;
    alm_cnt_d = alm_cnt_q;
    if (clr) begin
      st_d      = StIdle;
      alm_cnt_d = '0;
    end else if (trig) begin
      st_d      = StAlarm;
      alm_cnt_d = AlmLoad;
    end else begin
      unique case (st_q)
        StIdle: begin
          st_d = StIdle;
        end
        StAlarm: begin
          if (alm_cnt_q == '0) begin
            st_d = StIdle;
          end else begin
            alm_cnt_d = alm_cnt_q - AlmW'(1);
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      st_q      <= StIdle;
      alm_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      st_q      <= st_d;
      alm_cnt_q <= alm_cnt_d;
    end
  end

  // Outputs depend on registers only.
  assign A      = count_q[2];
  assign B      = count_q[1];
  assign C      = count_q[0];
  assign cheio  = (count_q == MaxCnt);
  assign vazio  = (count_q == 3'd0);
  assign alarme = (st_q == StAlarm);

endmodule
